fir_out_decim_fifo: RTL and testbench
=====================================

Name: fir_out_decim_fifo

Overview:
Downstream stage of the FIR tap chain. It consumes the full-width accumulator result on each clock-enabled sample and discards the pipeline warm-up samples. It decimates by a fixed factor, then rounds and saturates each kept result to bus width. Kept words are buffered in a small first-word-fall-through FIFO that the accelerator's bus-side read logic drains with a valid/ready handshake.

Parameters:
IW, 31, input result width; equals the FIR output width (2*12+7).
OW, 16, output word width, signed.
SHIFT, 11, right-shift (LSBs dropped) before saturation; 0 means no rounding.
DECIM, 4, keep 1 of every DECIM post-warm-up samples; must be >= 1.
NWARM, 5, number of initial accepted samples discarded; equals the FIR tap count.
DEPTH, 8, FIFO depth in words; power of 2, >= 2.

Ports:
i_clk  input  1  clock; all logic on its rising edge.
i_reset  input  1  synchronous, active-high reset.
i_ce  input  1  sample strobe, same strobe that advances the FIR.
i_result  input  IW  signed FIR result, valid when i_ce=1.
i_clear  input  1  synchronous flush: same effect as reset, one cycle.
o_data  output  OW  head-of-FIFO word, signed.
o_valid  output  1  FIFO non-empty.
i_ready  input  1  consumer pops the head when o_valid=1 and i_ready=1.
o_count  output  $clog2(DEPTH)+1  FIFO occupancy.
o_overflow  output  1  sticky: a kept word was dropped because the FIFO was full.
o_sat  output  1  sticky: at least one word saturated.

Behaviour:
- Reset/clear values: o_data=0, o_valid=0, o_count=0, o_overflow=0, o_sat=0. Warm-up counter, decimation phase, stage register and FIFO pointers all go to 0.
- Priority: i_reset > i_clear > normal operation. A clear while a sample is in the stage register discards that sample.
- A sample is accepted when i_ce=1. No action when i_ce=0.
- Warm-up:
  - While warm-up count < NWARM, each accepted sample increments the count and is discarded.
  - The count saturates at NWARM.
  - NWARM=0 means no warm-up.
- Decimation:
  - The phase counter runs 0..DECIM-1, advances on each post-warm-up accepted sample and wraps to 0.
  - A sample is kept when phase==0, so the first post-warm-up sample is kept.
- Round/saturate, combinational ahead of the stage register:
  - Sign-extend to IW+1 bits.
  - Add 2^(SHIFT-1) (round half up toward +inf).
  - Arithmetic shift right by SHIFT.
  - Clamp to [-2^(OW-1), 2^(OW-1)-1].
  - Clamping sets o_sat.
- Pipeline: a kept sample is registered into the stage at edge n and written to the FIFO at edge n+1. o_valid rises in the cycle after edge n+1, i.e. 2 cycles after the i_ce cycle. Throughput: 1 sample per cycle.
- FIFO, first-word-fall-through:
  - o_data shows the head word whenever o_valid=1.
  - A pop occurs on o_valid & i_ready.
  - i_ready while empty is ignored.
- Full FIFO:
  - Write with no pop in the same cycle: the word is dropped, o_overflow is set, and contents and count are unchanged.
  - Simultaneous pop and write: both happen, count stays DEPTH, no overflow.
- Empty FIFO: a write and an attempted pop in the same cycle perform the write only; the word appears next cycle.
- Pointers wrap modulo DEPTH. o_count ranges 0..DEPTH.
- Sticky flags clear only on i_reset or i_clear.

Decomposition:
- Package fir_out_pkg:
  - round_sat function (input value, SHIFT, OW → value and sat flag);
  - the count-width localparam;
  - a shared "DEPTH power of 2" elaboration check.
- Sub-module sync_fifo_fwft (parameters DW, DEPTH; ports wr_en/wr_data/full, rd_en/rd_data/empty, count, flush). It is reusable for other accelerator output paths.
- The top holds the warm-up and decimation counters, round/sat, the stage register and the sticky flags.

Test Plan:
- Reset, then 5 i_ce samples of 0x7FFFFFFF -> no o_valid, o_sat=0. Sixth sample 2048 -> o_data=0x0001 with o_valid high exactly 2 cycles after its i_ce cycle.
- Rounding after warm-up, DECIM=1 build: inputs 1024, 1023, -1024, -1025 -> outputs 0x0001, 0x0000, 0x0000, 0xFFFF.
- Saturation: 2^30-1 -> 0x7FFF with o_sat=1; -2^30 -> 0x8000. o_sat stays 1 until i_clear.
- Decimation, DECIM=4: post-warm-up inputs k*2048 for k=1..8 -> outputs 1 and 5 only, o_count=2.
- Back-pressure: i_ready=0 with 9 kept samples of values 1..9 -> o_count=8, o_overflow=1. Draining yields 1..8 in order. With the FIFO full, a pop and a write in the same cycle -> count stays 8 and o_overflow does not newly assert after a prior clear.
- i_clear mid-stream with 3 words buffered and one in the stage -> next cycle o_valid=0, o_count=0, flags 0. The next 5 samples are discarded (warm-up restarts) and the sixth is kept.

Source files
------------

// File: rtl/fir_out_pkg.sv
// Shared types and helpers for the FIR output decimation path:
// round/saturate arithmetic, FIFO count sizing and depth legality.
package fir_out_pkg;

  localparam int unsigned RS_W = 64;

  typedef logic signed [RS_W-1:0] rs_val_t;

  typedef struct packed {
    logic    sat;
    rs_val_t val;
  } rs_t;

  localparam int unsigned DEF_DEPTH = 8;

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int unsigned count_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned DEF_COUNT_W = count_w(DEF_DEPTH);

  function automatic bit depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  // Round half toward +inf, drop shift LSBs, clamp to a signed ow-bit range.
  function automatic rs_t round_sat(input rs_val_t x, input int unsigned shift,
                                    input int unsigned ow);
    rs_val_t v;
    rs_val_t hi;
    rs_val_t lo;
    rs_t     r;
    v = x;
    if (shift != 0) begin
      v = v + (rs_val_t'(1) <<< (shift - 1));
    end
    v     = v >>> shift;
    hi    = (rs_val_t'(1) <<< (ow - 1)) - rs_val_t'(1);
    lo    = -(rs_val_t'(1) <<< (ow - 1));
    r.sat = 1'b0;
    r.val = v;
    if (v > hi) begin
      r.sat = 1'b1;
      r.val = hi;
    end else if (v < lo) begin
      r.sat = 1'b1;
      r.val = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; the head word is visible on
// rd_data whenever empty is low. Shared by accelerator output paths.
module sync_fifo_fwft
  import fir_out_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      wr_en,
  input  logic [DW-1:0]             wr_data,
  output logic                      full,
  input  logic                      rd_en,
  output logic [DW-1:0]             rd_data,
  output logic                      empty,
  output logic [count_w(DEPTH)-1:0] count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = count_w(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_depth_chk
    $error("sync_fifo_fwft: DEPTH must be a power of 2 and >= 2");
  end

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr_c;
  logic          do_rd_c;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign rd_data = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a write.
  assign do_rd_c = rd_en && !empty;
  assign do_wr_c = wr_en && (!full || do_rd_c);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr_c) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_rd_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_wr_c, do_rd_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_decim_fifo.sv
// FIR output stage: drop warm-up samples, decimate, round/saturate to bus
// width and buffer kept words in a FWFT FIFO for the bus-side reader.
module fir_out_decim_fifo
  import fir_out_pkg::*;
#(
  parameter int unsigned IW    = 31,
  parameter int unsigned OW    = 16,
  parameter int unsigned SHIFT = 11,
  parameter int unsigned DECIM = 4,
  parameter int unsigned NWARM = 5,
  parameter int unsigned DEPTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_ce,
  input  logic signed [IW-1:0]      i_result,
  input  logic                      i_clear,
  output logic [OW-1:0]             o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [count_w(DEPTH)-1:0] o_count,
  output logic                      o_overflow,
  output logic                      o_sat
);

  localparam int unsigned WARM_W = (NWARM > 0) ? $clog2(NWARM + 1) : 1;
  localparam int unsigned PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;

  if (DECIM < 1) begin : g_decim_chk
    $error("fir_out_decim_fifo: DECIM must be >= 1");
  end

  logic [WARM_W-1:0]  warm_cnt;
  logic [PH_W-1:0]    phase;
  logic               warm_done_c;
  logic               keep_c;
  logic signed [IW:0] ext_c;
  rs_t                rs_c;
  logic               stage_vld;
  logic [OW-1:0]      stage_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               overflow_c;
  logic               flush_c;

  assign flush_c     = i_reset || i_clear;
  assign warm_done_c = (warm_cnt == WARM_W'(NWARM));
  assign keep_c      = i_ce && warm_done_c && (phase == '0);
  assign ext_c       = {i_result[IW-1], i_result};

  always_comb begin
    rs_c = round_sat(rs_val_t'(ext_c), SHIFT, OW);
  end

  // Warm-up count saturates at NWARM; the phase only runs once warm-up is over.
  always_ff @(posedge i_clk) begin
    if (flush_c) begin
      warm_cnt <= '0;
      phase    <= '0;
    end else if (i_ce) begin
      if (!warm_done_c) begin
        warm_cnt <= warm_cnt + WARM_W'(1);
      end else if (phase == PH_W'(DECIM - 1)) begin
        phase <= '0;
      end else begin
        phase <= phase + PH_W'(1);
      end
    end
  end

  // Stage register between round/saturate and the FIFO write port.
  always_ff @(posedge i_clk) begin
    if (flush_c) begin
      stage_vld  <= 1'b0;
      stage_data <= '0;
    end else begin
      stage_vld <= keep_c;
      if (keep_c) begin
        stage_data <= OW'(rs_c.val);
      end
    end
  end

  // A full FIFO only drops the staged word when the reader is not popping.
  assign overflow_c = stage_vld && fifo_full && !i_ready;

  always_ff @(posedge i_clk) begin
    if (flush_c) begin
      o_sat      <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (keep_c && rs_c.sat) begin
        o_sat <= 1'b1;
      end
      if (overflow_c) begin
        o_overflow <= 1'b1;
      end
    end
  end

  sync_fifo_fwft #(
    .DW    (OW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .reset   (i_reset),
    .flush   (i_clear),
    .wr_en   (stage_vld),
    .wr_data (stage_data),
    .full    (fifo_full),
    .rd_en   (i_ready),
    .rd_data (o_data),
    .empty   (fifo_empty),
    .count   (o_count)
  );

  assign o_valid = !fifo_empty;

endmodule

// File: tb/tb_fir_out_decim_fifo.sv
// Bench for fir_out_decim_fifo: directed scenarios then random traffic, all
// compared each cycle against a queue-based reference model.
module tb_fir_out_decim_fifo;

  localparam int IW    = 31;
  localparam int OW    = 16;
  localparam int SHIFT = 11;
  localparam int DECIM = 4;
  localparam int NWARM = 5;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam longint HALF = longint'(1) << (SHIFT - 1);
  localparam longint DIV  = longint'(1) << SHIFT;
  localparam longint MAXV = (longint'(1) << (OW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (OW - 1));

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_ce;
  logic [IW-1:0] i_result;
  logic          i_clear;
  logic [OW-1:0] o_data;
  logic          o_valid;
  logic          i_ready;
  logic [CW-1:0] o_count;
  logic          o_overflow;
  logic          o_sat;

  int n_checks = 0;
  int n_errs   = 0;

  int            m_warm;
  int            m_phase;
  bit            m_stage_v;
  logic [OW-1:0] m_stage_d;
  logic [OW-1:0] m_q[$];
  bit            m_ovf;
  bit            m_sat;

  always #5 i_clk = ~i_clk;

  fir_out_decim_fifo #(
    .IW(IW), .OW(OW), .SHIFT(SHIFT), .DECIM(DECIM), .NWARM(NWARM), .DEPTH(DEPTH)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_ce       (i_ce),
    .i_result   (i_result),
    .i_clear    (i_clear),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .o_sat      (o_sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Floor division of (x + half) by 2^SHIFT, then clamp to the output range.
  function automatic logic [OW-1:0] ref_round(input longint x, output bit sat);
    longint y;
    longint q;
    y = x + HALF;
    if (y >= 0) q = y / DIV;
    else        q = -((-y + DIV - 1) / DIV);
    sat = 1'b0;
    if (q > MAXV) begin
      q = MAXV; sat = 1'b1;
    end else if (q < MINV) begin
      q = MINV; sat = 1'b1;
    end
    return OW'(q);
  endfunction

  task automatic model_step();
    bit keep;
    bit s;
    if (i_reset || i_clear) begin
      m_warm = 0; m_phase = 0; m_stage_v = 0;
      m_q.delete(); m_ovf = 0; m_sat = 0;
      return;
    end
    if (m_q.size() > 0 && i_ready) void'(m_q.pop_front());
    if (m_stage_v) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_stage_d);
      else m_ovf = 1'b1;
    end
    keep = 1'b0;
    if (i_ce) begin
      if (m_warm < NWARM) m_warm++;
      else begin
        keep    = (m_phase == 0);
        m_phase = (m_phase + 1) % DECIM;
      end
    end
    m_stage_v = keep;
    if (keep) begin
      m_stage_d = ref_round(longint'($signed(i_result)), s);
      if (s) m_sat = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("valid", 32'(o_valid), 32'(m_q.size() > 0));
    chk("count", 32'(o_count), 32'(m_q.size()));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
    chk("sat", 32'(o_sat), 32'(m_sat));
    if (m_q.size() > 0) chk("data", 32'(o_data), 32'(m_q[0]));
  endtask

  task automatic tick(input bit ce, input int res, input bit clr, input bit rdy);
    i_ce = ce; i_result = IW'(res); i_clear = clr; i_ready = rdy;
    model_step();
    @(posedge i_clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 1'b0, rdy);
  endtask

  // One kept sample followed by the samples that decimation discards.
  task automatic kept(input int v);
    tick(1'b1, v, 1'b0, 1'b0);
    for (int i = 1; i < DECIM; i++) tick(1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic rewarm();
    tick(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < NWARM; i++) tick(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0);
  endtask

  task automatic drain_expect(input logic [OW-1:0] exp);
    chk("drain_valid", 32'(o_valid), 32'd1);
    chk("drain_data", 32'(o_data), 32'(exp));
    tick(1'b0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    int v;
    i_reset = 1'b1; i_ce = 1'b0; i_result = '0; i_clear = 1'b0; i_ready = 1'b0;
    idle(2, 1'b0);
    i_reset = 1'b0;
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_flags", 32'({o_overflow, o_sat}), 32'd0);

    // Warm-up discards five saturating samples; sixth is kept with 2-cycle latency.
    for (int i = 0; i < NWARM; i++) tick(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0);
    chk("warm_valid", 32'(o_valid), 32'd0);
    chk("warm_sat", 32'(o_sat), 32'd0);
    tick(1'b1, 2048, 1'b0, 1'b0);
    chk("lat1_valid", 32'(o_valid), 32'd0);
    tick(1'b0, 0, 1'b0, 1'b0);
    chk("lat2_valid", 32'(o_valid), 32'd1);
    drain_expect(16'h0001);

    // Rounding around the half-LSB point.
    rewarm();
    kept(1024); kept(1023); kept(-1024); kept(-1025);
    idle(2, 1'b0);
    drain_expect(16'h0001); drain_expect(16'h0000);
    drain_expect(16'h0000); drain_expect(16'hFFFF);

    // Saturation at both rails; sticky until clear.
    kept(32'h3FFF_FFFF);
    chk("sat_set", 32'(o_sat), 32'd1);
    kept(-32'sh4000_0000);
    idle(2, 1'b0);
    drain_expect(16'h7FFF); drain_expect(16'h8000);
    chk("sat_sticky", 32'(o_sat), 32'd1);
    tick(1'b0, 0, 1'b1, 1'b0);
    chk("sat_clr", 32'(o_sat), 32'd0);

    // Decimation by 4 of k*2048 keeps k=1 and k=5.
    rewarm();
    for (int k = 1; k <= 8; k++) tick(1'b1, k * 2048, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("decim_count", 32'(o_count), 32'd2);
    drain_expect(16'd1); drain_expect(16'd5);

    // Back-pressure overflow, then in-order drain.
    rewarm();
    for (int k = 1; k <= 9; k++) kept(k * 2048);
    idle(2, 1'b0);
    chk("bp_count", 32'(o_count), 32'd8);
    chk("bp_ovf", 32'(o_overflow), 32'd1);
    for (int k = 1; k <= 8; k++) drain_expect(OW'(k));
    chk("bp_empty", 32'(o_count), 32'd0);

    // Full FIFO: pop and write in the same cycle.
    rewarm();
    for (int k = 1; k <= 8; k++) kept(k * 2048);
    idle(2, 1'b0);
    tick(1'b1, 9 * 2048, 1'b0, 1'b0);
    tick(1'b0, 0, 1'b0, 1'b1);
    chk("fullrw_count", 32'(o_count), 32'd8);
    chk("fullrw_ovf", 32'(o_overflow), 32'd0);
    for (int k = 2; k <= 9; k++) drain_expect(OW'(k));

    // Clear with three words buffered and one staged.
    rewarm();
    kept(32'h3FFF_FFFF); kept(2 * 2048); kept(3 * 2048);
    tick(1'b1, 4 * 2048, 1'b0, 1'b0);
    tick(1'b0, 0, 1'b1, 1'b0);
    chk("clr_valid", 32'(o_valid), 32'd0);
    chk("clr_count", 32'(o_count), 32'd0);
    chk("clr_flags", 32'({o_overflow, o_sat}), 32'd0);
    for (int i = 0; i < NWARM; i++) tick(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("clr_warm_count", 32'(o_count), 32'd0);
    tick(1'b1, 6 * 2048, 1'b0, 1'b0);
    idle(1, 1'b0);
    drain_expect(16'd6);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) v = int'($urandom);
      else v = int'($urandom_range(0, 32'h0800_0000)) - 32'sh0400_0000;
      tick($urandom_range(0, 3) != 0, v, $urandom_range(0, 199) == 0,
           $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
